// File: rtl/water_supply_counter_pkg.sv
// water_supply_pkg: shared FSM state type and tank level constants for the water supply counter.
package water_supply_pkg;
    localparam int LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = 3'd0;
    localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = 3'd7;
    localparam logic [LEVEL_W-1:0] LOW_ALARM_LEVEL = 3'd6;
    typedef enum logic [1:0] {IDLE, DRAINING, EMPTY, REFILLING} state_t;
endpackage

// File: rtl/water_supply_counter_step_divider.sv
// water_step_divider: counts tick pulses and emits a one-cycle step when the terminal count is reached.
module water_step_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    input  logic [7:0] term,
    output logic       step
);
    logic [7:0] count;
    assign step = tick && (count == term - 8'd1);
    always_ff @(posedge clk) begin
        if (reset || clear) count <= 8'd0;
        else if (tick) count <= step ? 8'd0 : count + 8'd1;
    end
endmodule

// File: rtl/water_supply_counter.sv
// water_supply_counter: tank level FSM draining/refilling on prescaled ticks.
// Optional LOW_LEVEL_ALARM_EN drives low_alarm when the tank is nearly empty.
module water_supply_counter
    import water_supply_pkg::*;
#(
    parameter int DRAIN_TICKS = 4,
    parameter int REFILL_TICKS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               valve_open,
    input  logic               refill_req,
    output logic [LEVEL_W-1:0] water_level,
    output logic               irrigating,
    output logic               pump_on,
    output logic               tank_full,
    output logic               tank_empty,
    output logic               low_alarm
);
    state_t state, next_state;
    logic [LEVEL_W-1:0] next_level;
    logic step;
    water_step_divider u_div (
        .clk(clk),
        .reset(reset),
        .tick(tick && (state == DRAINING || state == REFILLING)),
        .clear(next_state != state),
        .term(state == REFILLING ? 8'(REFILL_TICKS) : 8'(DRAIN_TICKS)),
        .step(step)
    );
    // refill_req outranks everything except an ongoing refill
    always_comb begin
        next_state = state;
        next_level = water_level;
        if (refill_req && water_level != LEVEL_FULL && state != REFILLING)
            next_state = REFILLING;
        else if (state == IDLE && valve_open && water_level != LEVEL_EMPTY)
            next_state = DRAINING;
        else if (state == DRAINING && !valve_open)
            next_state = IDLE;
        else if (step) begin
            next_level = state == DRAINING ? water_level + 3'd1 : water_level - 3'd1;
            next_state = (state == DRAINING && next_level == LEVEL_EMPTY) ? EMPTY :
                         (state == REFILLING && next_level == LEVEL_FULL) ? IDLE : state;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            water_level <= LEVEL_FULL;
            irrigating <= 1'b0;
            pump_on <= 1'b0;
            tank_full <= 1'b1;
            tank_empty <= 1'b0;
        end else begin
            state <= next_state;
            water_level <= next_level;
            irrigating <= next_state == DRAINING;
            pump_on <= next_state == REFILLING;
            tank_full <= next_level == LEVEL_FULL;
            tank_empty <= next_level == LEVEL_EMPTY;
        end
    end
`ifdef LOW_LEVEL_ALARM_EN
    always_ff @(posedge clk) low_alarm <= reset ? 1'b0 : next_level >= LOW_ALARM_LEVEL;
`else
    assign low_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_water_supply_counter.sv
// tb_water_supply_counter: directed stimulus against a tank-level model, checked every cycle.
module tb_water_supply_counter;
    localparam int DT = 4;
    localparam int RT = 2;
    logic clk = 1'b0;
    logic reset = 1'b1, tick = 1'b0, valve_open = 1'b0, refill_req = 1'b0;
    logic [2:0] water_level;
    logic irrigating, pump_on, tank_full, tank_empty, low_alarm;
    int checks = 0, errors = 0;
    int m_st = 0, m_lvl = 0, m_acc = 0;
    bit live = 0;

    water_supply_counter #(.DRAIN_TICKS(DT), .REFILL_TICKS(RT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .valve_open(valve_open),
        .refill_req(refill_req), .water_level(water_level), .irrigating(irrigating),
        .pump_on(pump_on), .tank_full(tank_full), .tank_empty(tank_empty),
        .low_alarm(low_alarm)
    );

    always #5 clk = ~clk;

    function automatic int exp_alarm(int lvl);
`ifdef LOW_LEVEL_ALARM_EN
        return int'(lvl >= 6);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", n, act, want, $time);
        end
    endtask

    // model: 0 idle, 1 draining, 2 empty, 3 refilling; m_acc = ticks gathered toward next level change
    task automatic cyc(input logic t, input logic v, input logic r, input logic rs = 1'b0);
        tick = t; valve_open = v; refill_req = r; reset = rs;
        @(posedge clk);
        if (rs) begin
            m_st = 0; m_lvl = 0; m_acc = 0;
        end else if (m_st != 3 && r && m_lvl != 0) begin
            m_st = 3; m_acc = 0;
        end else if (m_st == 0 && v && m_lvl < 7) begin
            m_st = 1; m_acc = 0;
        end else if (m_st == 1 && !v) begin
            m_st = 0; m_acc = 0;
        end else if ((m_st == 1 || m_st == 3) && t) begin
            m_acc++;
            if (m_st == 1 && m_acc == DT) begin
                m_acc = 0; m_lvl++;
                if (m_lvl == 7) m_st = 2;
            end else if (m_st == 3 && m_acc == RT) begin
                m_acc = 0; m_lvl--;
                if (m_lvl == 0) m_st = 0;
            end
        end
        live = 1;
        #1;
    endtask

    always @(negedge clk) if (live) begin
        chk("level", 8'(water_level), 8'(m_lvl));
        chk("irrigating", 8'(irrigating), 8'(m_st == 1));
        chk("pump_on", 8'(pump_on), 8'(m_st == 3));
        chk("tank_full", 8'(tank_full), 8'(m_lvl == 0));
        chk("tank_empty", 8'(tank_empty), 8'(m_lvl == 7));
        chk("low_alarm", 8'(low_alarm), 8'(exp_alarm(m_lvl)));
    end

    initial begin
        cyc(0, 0, 0, 1);
        chk("rst_full", 8'(tank_full), 8'd1);
        chk("rst_level", 8'(water_level), 8'd0);
        repeat (3) cyc(1, 0, 0);
        chk("idle_tick_level", 8'(water_level), 8'd0);
        cyc(1, 1, 0);
        repeat (4) cyc(1, 1, 0);
        chk("drain_first_step", 8'(water_level), 8'd1);
        repeat (24) cyc(1, 1, 0);
        chk("drain_empty_level", 8'(water_level), 8'd7);
        chk("drain_empty_flag", 8'(tank_empty), 8'd1);
        chk("drain_empty_irrig", 8'(irrigating), 8'd0);
        cyc(1, 1, 0);
        chk("empty_holds", 8'(water_level), 8'd7);
        cyc(1, 1, 1);
        chk("refill_pump", 8'(pump_on), 8'd1);
        repeat (14) cyc(1, 1, 0);
        chk("refill_done_level", 8'(water_level), 8'd0);
        chk("refill_done_full", 8'(tank_full), 8'd1);
        chk("refill_done_pump", 8'(pump_on), 8'd0);
        cyc(0, 1, 0);
        repeat (3) cyc(1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        repeat (3) cyc(1, 1, 0);
        chk("pause_no_step", 8'(water_level), 8'd0);
        cyc(1, 1, 0);
        chk("pause_fresh_step", 8'(water_level), 8'd1);
        repeat (8) begin
            cyc(1, 1, 0);
            cyc(0, 1, 0);
        end
        chk("sparse_tick_level", 8'(water_level), 8'd3);
        cyc(1, 1, 1);
        chk("prio_pump", 8'(pump_on), 8'd1);
        chk("prio_irrig", 8'(irrigating), 8'd0);
        chk("prio_level", 8'(water_level), 8'd3);
        repeat (6) cyc(1, 1, 0);
        chk("prio_refilled", 8'(tank_full), 8'd1);
        cyc(0, 0, 1);
        chk("full_refill_ign", 8'(pump_on), 8'd0);
        cyc(0, 1, 0);
        repeat (16) cyc(1, 1, 0);
        chk("mid_level4", 8'(water_level), 8'd4);
        cyc(0, 1, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0, 1);
        chk("abort_level", 8'(water_level), 8'd0);
        chk("abort_pump", 8'(pump_on), 8'd0);
        chk("abort_full", 8'(tank_full), 8'd1);
        cyc(0, 1, 0);
        repeat (24) cyc(1, 1, 0);
        chk("alarm_at6", 8'(water_level), 8'd6);
`ifdef LOW_LEVEL_ALARM_EN
        chk("alarm_high", 8'(low_alarm), 8'd1);
`else
        chk("alarm_tied", 8'(low_alarm), 8'd0);
`endif
        cyc(0, 1, 1);
        repeat (2) cyc(1, 0, 0);
        chk("alarm_level5", 8'(water_level), 8'd5);
        chk("alarm_low", 8'(low_alarm), 8'd0);
        repeat (300) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 23) == 0), 1'($urandom_range(0, 99) == 0));
        live = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/water_supply_counter.md
WATER_SUPPLY_COUNTER -- requirements
Module: water_supply_counter

Interface
REQ-001 Parameter DRAIN_TICKS, default 4: tick pulses per one-level drop while draining; legal range 1..255.
REQ-002 Parameter REFILL_TICKS, default 2: tick pulses per one-level rise while refilling; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port tick  input  1  one-cycle timebase enable from the system prescaler.
REQ-006 Port valve_open  input  1  level request from irrigation control; high = consume water.
REQ-007 Port refill_req  input  1  one-cycle refill command.
REQ-008 Port water_level  output  3  encoded consumption count; 0 = full, 7 = empty; feeds the matrix column decoder.
REQ-009 Port irrigating  output  1  high only in DRAINING.
REQ-010 Port pump_on  output  1  high only in REFILLING.
REQ-011 Port tank_full  output  1  high when water_level == 0.
REQ-012 Port tank_empty  output  1  high when water_level == 7.
REQ-013 Port low_alarm  output  1  low-water alarm (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, DRAINING, EMPTY, REFILLING.
REQ-015 IDLE -> REFILLING on refill_req with water_level != 0; else IDLE -> DRAINING on valve_open with water_level < 7.
REQ-016 DRAINING: step counter SHALL increment on each tick; on the tick making it DRAIN_TICKS, water_level +1 and step counter -> 0.
REQ-017 DRAINING -> EMPTY on the same edge water_level becomes 7; DRAINING -> IDLE when valve_open low, step counter cleared.
REQ-018 EMPTY: irrigating low regardless of valve_open; only refill_req leaves EMPTY (-> REFILLING).
REQ-019 REFILLING: each REFILL_TICKS ticks water_level -1; on reaching 0 -> IDLE; valve_open and further refill_req ignored.
REQ-020 refill_req SHALL take priority over valve_open in the same cycle, from IDLE, DRAINING or EMPTY; step counter cleared on entry.
REQ-021 refill_req with water_level == 0 SHALL be ignored.
REQ-022 water_level SHALL saturate at 0 and 7; never wrap.
REQ-023 tick without DRAINING/REFILLING SHALL have no effect; all outputs registered, update on the edge where the completing tick is sampled.
REQ-024 tank_full, tank_empty, irrigating, pump_on SHALL be consistent with water_level and state in the same cycle.

Reset
REQ-025 On reset: state IDLE, water_level 0, step counter 0, tank_full 1, tank_empty/irrigating/pump_on/low_alarm 0.
REQ-026 Reset mid-DRAINING or mid-REFILLING SHALL abort immediately; tank assumed full after reset.

Configuration
REQ-027 Macro LOW_LEVEL_ALARM_EN defined: low_alarm registered high when water_level >= 6, else low.
REQ-028 Macro not defined: low_alarm port present, tied constant 0; no other behavioural change.

Structure
REQ-029 Package water_supply_pkg SHALL hold the state enum, LEVEL_W = 3, LEVEL_FULL = 0, LEVEL_EMPTY = 7, LOW_ALARM_LEVEL = 6.
REQ-030 Step counting SHALL be one sub-module, water_step_divider (tick in, clear, terminal count in, step pulse out).

Verification
REQ-031 Reset, valve_open = 1, tick every cycle, DRAIN_TICKS = 4 -> water_level 1 after 4 ticks, 7 and EMPTY after 28, irrigating drops same edge.
REQ-032 At level 7, refill_req, REFILL_TICKS = 2, tick every cycle -> pump_on 1, level 0 after 14 ticks, tank_full 1, state IDLE.
REQ-033 Draining, 3 ticks then valve_open low, then valve_open high -> level unchanged, 4 fresh ticks required for next step.
REQ-034 refill_req and valve_open same cycle at level 3 -> REFILLING, pump_on 1, irrigating 0.
REQ-035 refill_req at level 0; reset asserted mid-refill at level 4 -> ignored; next cycle level 0, pump_on 0, tank_full 1.
REQ-036 With LOW_LEVEL_ALARM_EN: low_alarm rises when level reaches 6, falls when refill brings it to 5; without macro stays 0.
